// File: rtl/mmio_pkg.sv
// Shared definitions for the memory-mapped UART transmitter: register offsets, STATUS layout,
// transmitter FSM states.
package mmio_pkg;

  localparam logic [31:0] OffTxdata = 32'h0;
  localparam logic [31:0] OffStatus = 32'h4;
  localparam logic [31:0] OffDiv    = 32'h8;

  localparam int unsigned StatusBusyBit  = 0;
  localparam int unsigned StatusFullBit  = 1;
  localparam int unsigned StatusEmptyBit = 2;
  localparam int unsigned StatusOvfBit   = 3;
  localparam int unsigned StatusCountLsb = 4;

  typedef enum logic [1:0] {StIdle, StStart, StData, StStop} uart_tx_state_t;

  // A programmed divisor of zero runs at one clock per bit.
  function automatic logic [15:0] eff_div(input logic [15:0] div);
    return (div == 16'd0) ? 16'd1 : div;
  endfunction

endpackage

// File: rtl/mmio_fifo.sv
// Synchronous FIFO with occupancy count; DEPTH must be a power of two (>= 2) so pointers wrap.
module mmio_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4,
  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int unsigned CW = $clog2(DEPTH + 1)
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic [WIDTH-1:0] i_wdata,
  output logic [WIDTH-1:0] o_rdata,
  output logic             o_full,
  output logic             o_empty,
  output logic [CW-1:0]    o_count
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [CW-1:0]    r_count;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (i_push) r_wptr <= r_wptr + 1'b1;
      if (i_pop)  r_rptr <= r_rptr + 1'b1;
      if (i_push && !i_pop) begin
        r_count <= r_count + 1'b1;
      end else if (!i_push && i_pop) begin
        r_count <= r_count - 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_push) r_mem[r_wptr] <= i_wdata;
  end

  assign o_rdata = r_mem[r_rptr];
  assign o_full  = (r_count == CW'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_count = r_count;

endmodule

// File: rtl/mmio_uart_tx.sv
// CPU-visible UART transmitter: TXDATA/STATUS/DIV register window, transmit FIFO and an
// 8N1 serializer whose bit time is latched per frame.
module mmio_uart_tx
  import mmio_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = 32'hFFFF0000,
  parameter int unsigned FIFO_DEPTH  = 4,
  parameter int unsigned DEFAULT_DIV = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        memwrite,
  input  logic [31:0] dataadr,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic        txd
);

  localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);
  localparam logic [31:0] TxdataAddr = BASE_ADDR + OffTxdata;
  localparam logic [31:0] StatusAddr = BASE_ADDR + OffStatus;
  localparam logic [31:0] DivAddr    = BASE_ADDR + OffDiv;
  localparam logic [15:0] DefaultDiv = 16'(DEFAULT_DIV);

  uart_tx_state_t r_state;
  logic [7:0]     r_shift;
  logic [2:0]     r_bit_cnt;
  logic [15:0]    r_cyc_cnt;
  logic [15:0]    r_div_lat;
  logic [15:0]    r_div;
  logic           r_ovf;
  logic           r_txd;

  logic           w_sel_txdata, w_sel_status, w_sel_div;
  logic           w_fifo_full, w_fifo_empty;
  logic [CW-1:0]  w_fifo_count;
  logic [7:0]     w_fifo_rdata;
  logic           w_bit_done, w_pop, w_push, w_busy;
  logic           w_unused_bits;

  assign w_sel_txdata  = (dataadr[31:2] == TxdataAddr[31:2]);
  assign w_sel_status  = (dataadr[31:2] == StatusAddr[31:2]);
  assign w_sel_div     = (dataadr[31:2] == DivAddr[31:2]);
  assign w_unused_bits = ^{dataadr[1:0], writedata[31:16]};

  assign w_busy     = (r_state != StIdle);
  assign w_bit_done = (r_cyc_cnt == r_div_lat - 16'd1);
  // Pop from idle, or at the last clock of STOP so frames run back-to-back.
  assign w_pop  = !w_fifo_empty && ((r_state == StIdle) || ((r_state == StStop) && w_bit_done));
  assign w_push = memwrite && w_sel_txdata && (!w_fifo_full || w_pop);

  mmio_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_clk   (clk),
    .i_rst   (reset),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_wdata (writedata[7:0]),
    .o_rdata (w_fifo_rdata),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty),
    .o_count (w_fifo_count)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ovf <= 1'b0;
      r_div <= DefaultDiv;
    end else if (memwrite) begin
      if (w_sel_txdata && w_fifo_full && !w_pop) r_ovf <= 1'b1;
      if (w_sel_status) r_ovf <= 1'b0;
      if (w_sel_div)    r_div <= writedata[15:0];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= StIdle;
      r_shift   <= '0;
      r_bit_cnt <= '0;
      r_cyc_cnt <= '0;
      r_div_lat <= eff_div(DefaultDiv);
      r_txd     <= 1'b1;
    end else if (w_pop) begin
      r_state   <= StStart;
      r_shift   <= w_fifo_rdata;
      r_div_lat <= eff_div(r_div);
      r_bit_cnt <= '0;
      r_cyc_cnt <= '0;
      r_txd     <= 1'b0;
    end else begin
      unique case (r_state)
        StIdle: r_txd <= 1'b1;
        StStart: begin
          if (w_bit_done) begin
            r_state   <= StData;
            r_cyc_cnt <= '0;
            r_txd     <= r_shift[0];
          end else begin
            r_cyc_cnt <= r_cyc_cnt + 16'd1;
          end
        end
        StData: begin
          if (w_bit_done) begin
            r_cyc_cnt <= '0;
            if (r_bit_cnt == 3'd7) begin
              r_state <= StStop;
              r_txd   <= 1'b1;
            end else begin
              r_bit_cnt <= r_bit_cnt + 3'd1;
              r_shift   <= r_shift >> 1;
              r_txd     <= r_shift[1];
            end
          end else begin
            r_cyc_cnt <= r_cyc_cnt + 16'd1;
          end
        end
        StStop: begin
          if (w_bit_done) begin
            r_state   <= StIdle;
            r_cyc_cnt <= '0;
          end else begin
            r_cyc_cnt <= r_cyc_cnt + 16'd1;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  always_comb begin
    readdata = '0;
    if (w_sel_status) begin
      readdata[StatusBusyBit]       = w_busy;
      readdata[StatusFullBit]       = w_fifo_full;
      readdata[StatusEmptyBit]      = w_fifo_empty;
      readdata[StatusOvfBit]        = r_ovf;
      readdata[StatusCountLsb +: 3] = 3'(w_fifo_count);
    end else if (w_sel_div) begin
      readdata[15:0] = r_div;
    end
  end

  assign txd = r_txd;

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Bench for mmio_uart_tx: frame-level reference model checked every cycle, directed scenarios
// with hand-computed expectations, then randomized register traffic.
module tb_mmio_uart_tx;

  localparam logic [31:0] BASE     = 32'hFFFF0000;
  localparam logic [31:0] ADDR_TX  = BASE;
  localparam logic [31:0] ADDR_ST  = BASE + 32'd4;
  localparam logic [31:0] ADDR_DIV = BASE + 32'd8;
  localparam logic [31:0] ADDR_UNM = BASE + 32'd12;
  localparam int          DEPTH    = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        memwrite = 1'b0;
  logic [31:0] dataadr = ADDR_ST;
  logic [31:0] writedata = '0;
  logic [31:0] readdata;
  logic        txd;
  logic        chk_en = 1'b0;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  mmio_uart_tx #(
    .BASE_ADDR   (BASE),
    .FIFO_DEPTH  (DEPTH),
    .DEFAULT_DIV (16)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .memwrite  (memwrite),
    .dataadr   (dataadr),
    .writedata (writedata),
    .readdata  (readdata),
    .txd       (txd)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a byte queue and the frame currently on the line.
  logic [7:0]  m_q[$];
  logic [7:0]  m_hd;
  bit          m_active = 1'b0;
  logic [9:0]  m_bits = '1;
  int unsigned m_t = 0;
  int unsigned m_fdiv = 16;
  logic [15:0] m_div = 16'd16;
  bit          m_ovf = 1'b0;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_q.delete();
      m_active = 1'b0;
      m_t      = 0;
      m_ovf    = 1'b0;
      m_div    = 16'd16;
    end else begin
      if (m_active) begin
        m_t++;
        if (m_t == 10 * m_fdiv) m_active = 1'b0;
      end
      if (!m_active && m_q.size() != 0) begin
        m_hd     = m_q.pop_front();
        m_bits   = {1'b1, m_hd, 1'b0};
        m_fdiv   = (m_div == 16'd0) ? 1 : int'(m_div);
        m_t      = 0;
        m_active = 1'b1;
      end
      if (memwrite) begin
        if ((dataadr >> 2) == (ADDR_TX >> 2)) begin
          if (m_q.size() < DEPTH) m_q.push_back(writedata[7:0]);
          else m_ovf = 1'b1;
        end else if ((dataadr >> 2) == (ADDR_ST >> 2)) begin
          m_ovf = 1'b0;
        end else if ((dataadr >> 2) == (ADDR_DIV >> 2)) begin
          m_div = writedata[15:0];
        end
      end
    end
  end

  function automatic logic exp_txd();
    return m_active ? m_bits[m_t / m_fdiv] : 1'b1;
  endfunction

  function automatic logic [31:0] exp_read(input logic [31:0] a);
    logic [31:0] s;
    s = '0;
    if ((a >> 2) == (ADDR_ST >> 2)) begin
      s[6:4] = 3'(m_q.size());
      s[3]   = m_ovf;
      s[2]   = (m_q.size() == 0);
      s[1]   = (m_q.size() == DEPTH);
      s[0]   = m_active;
    end else if ((a >> 2) == (ADDR_DIV >> 2)) begin
      s = {16'b0, m_div};
    end
    return s;
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      check("model txd", 32'(txd), 32'(exp_txd()));
      check("model readdata", readdata, exp_read(dataadr));
    end
  end

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    @(posedge clk);
    #1 memwrite = 1'b1;
    dataadr   = a;
    writedata = d;
    @(posedge clk);
    #1 memwrite = 1'b0;
    dataadr   = ADDR_ST;
    writedata = $urandom;
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] v);
    @(posedge clk);
    #1 dataadr = a;
    @(negedge clk);
    v = readdata;
  endtask

  // pat[0] is the first bit on the line (start bit).
  task automatic expect_frame(input string name, input logic [9:0] pat, input int div);
    for (int i = 0; i < 10; i++) begin
      for (int k = 0; k < div; k++) begin
        @(posedge clk);
        @(negedge clk);
        check(name, 32'(txd), 32'(pat[i]));
      end
    end
    @(posedge clk);
    @(negedge clk);
    check({name, " busy after"}, readdata & 32'h1, 32'h0);
  endtask

  logic [31:0] v;
  logic        rec [121];
  int          c;

  initial begin
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    chk_en = 1'b1;

    // Reset state.
    rd(ADDR_ST, v);  check("reset status", v, 32'h04);
    check("reset txd", 32'(txd), 32'h1);
    rd(ADDR_DIV, v); check("reset div", v, 32'd16);
    rd(ADDR_TX, v);  check("txdata reads 0", v, 32'h0);

    // 0x55 at 4 clocks per bit.
    wr(ADDR_DIV, 32'd4);
    wr(ADDR_TX, 32'h55);
    expect_frame("frame 55 div4", 10'b1010101010, 4);

    // Divisor 0 behaves as 1.
    wr(ADDR_DIV, 32'd0);
    wr(ADDR_TX, 32'hA3);
    expect_frame("frame A3 div0", 10'b1101000110, 1);

    // Six consecutive stores: five transmitted back-to-back, sixth dropped.
    wr(ADDR_DIV, 32'd16);
    @(posedge clk);
    #1 memwrite = 1'b1;
    dataadr   = ADDR_TX;
    writedata = 32'h11;
    for (int i = 1; i < 6; i++) begin
      @(posedge clk);
      #1 writedata = 32'h11 * (i + 1);
    end
    @(posedge clk);
    #1 memwrite = 1'b0;
    dataadr = ADDR_ST;
    @(negedge clk);
    check("burst status full+ovf", readdata, 32'h4B);
    c = 0;
    for (int k = 0; k < 2000; k++) begin
      @(negedge clk);
      if (!readdata[0]) break;
      c++;
    end
    check("burst busy cycles", 32'(c), 32'd795);
    check("burst status idle ovf", readdata, 32'h0C);
    wr(ADDR_ST, 32'hDEADBEEF);
    rd(ADDR_ST, v);  check("ovf cleared", v, 32'h04);

    // Reset during data bit 3 with two bytes queued.
    @(posedge clk);
    #1 memwrite = 1'b1;
    dataadr   = ADDR_TX;
    writedata = 32'hC3;
    @(posedge clk);
    #1 writedata = 32'h3C;
    @(posedge clk);
    #1 writedata = 32'h5A;
    @(posedge clk);
    #1 memwrite = 1'b0;
    dataadr = ADDR_ST;
    repeat (67) @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    check("reset mid-frame txd", 32'(txd), 32'h1);
    check("reset mid-frame status", readdata, 32'h04);
    rd(ADDR_DIV, v); check("reset mid-frame div", v, 32'd16);
    @(posedge clk);
    #1 reset = 1'b0;
    dataadr = ADDR_ST;
    c = 0;
    for (int k = 0; k < 700; k++) begin
      @(negedge clk);
      if (!txd) c++;
    end
    check("no frame after reset", 32'(c), 32'd0);

    // DIV store mid-frame affects only the next frame.
    wr(ADDR_DIV, 32'd4);
    wr(ADDR_TX, 32'h01);
    for (int i = 0; i < 121; i++) begin
      @(posedge clk);
      #1 memwrite = (i == 8) || (i == 9);
      dataadr   = (i == 8) ? ADDR_DIV : (i == 9) ? ADDR_TX : ADDR_ST;
      writedata = (i == 8) ? 32'd8 : 32'h01;
      @(negedge clk);
      rec[i] = txd;
    end
    check("div4 start", 32'(rec[3]), 32'h0);
    check("div4 bit0", 32'(rec[4]), 32'h1);
    check("div4 bit1", 32'(rec[8]), 32'h0);
    check("div4 stop", 32'(rec[39]), 32'h1);
    check("div8 start first", 32'(rec[40]), 32'h0);
    check("div8 start last", 32'(rec[47]), 32'h0);
    check("div8 bit0 first", 32'(rec[48]), 32'h1);
    check("div8 bit0 last", 32'(rec[55]), 32'h1);
    check("div8 bit1", 32'(rec[56]), 32'h0);
    check("div8 stop", 32'(rec[119]), 32'h1);
    rd(ADDR_ST, v);  check("idle after div8", v, 32'h04);
    rd(ADDR_UNM, v); check("unmapped +12", v, 32'h0);
    rd(BASE + 32'h10, v); check("unmapped +16", v, 32'h0);

    // Randomized traffic against the model.
    for (int i = 0; i < 4000; i++) begin
      int sel;
      @(posedge clk);
      #1;
      if (reset) reset = 1'b0;
      else if ($urandom_range(0, 199) == 0) reset = 1'b1;
      memwrite = ($urandom_range(0, 99) < 25);
      sel = $urandom_range(0, 9);
      writedata = $urandom;
      if (sel < 6) begin
        dataadr = ADDR_TX | 32'($urandom_range(0, 3));
      end else if (sel == 6) begin
        dataadr = ADDR_ST | 32'($urandom_range(0, 3));
      end else if (sel == 7) begin
        dataadr   = ADDR_DIV | 32'($urandom_range(0, 3));
        writedata = (writedata & 32'hFFFF0000) | 32'($urandom_range(0, 3));
      end else if (sel == 8) begin
        dataadr = ADDR_UNM;
      end else begin
        dataadr = $urandom;
      end
    end
    @(posedge clk);
    #1 memwrite = 1'b0;
    reset   = 1'b0;
    dataadr = ADDR_ST;
    repeat (200) @(posedge clk);
    @(negedge clk);
    chk_en = 1'b0;

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
